// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for pipeline_ctrl: stage indices, FSM encoding, stall/flush bus width.
// Optional perf counters are enabled with PERF_CNT_EN.
`ifndef PIPELINE_CTRL_DEFS
`define PIPELINE_CTRL_DEFS
`define PIPE_REG_W 5
`endif

package pipeline_ctrl_pkg;
   localparam int STG_IF  = 0;
   localparam int STG_ID  = 1;
   localparam int STG_EX  = 2;
   localparam int STG_MEM = 3;

   localparam logic [0:0] ST_RUN        = 1'b0;
   localparam logic [0:0] ST_REDIR_WAIT = 1'b1;

   // Every register downstream of the PC is bubbled on an exception.
   localparam logic [`PIPE_REG_W-1:0] EXC_FLUSH = 5'b11110;
   localparam logic [`PIPE_REG_W-1:0] RST_STALL = 5'b11111;

   // Hold the requesting stage and everything upstream of it.
   function automatic logic [`PIPE_REG_W-1:0] hold_mask(input logic [2:0] k);
      hold_mask = '0;
      for (int i = 0; i < `PIPE_REG_W; i++)
         if (i <= int'(k)) hold_mask[i] = 1'b1;
   endfunction

   // Bubble the register just downstream of the held stage.
   function automatic logic [`PIPE_REG_W-1:0] bubble_mask(input logic [2:0] k);
      bubble_mask = `PIPE_REG_W'(1) << (k + 3'd1);
   endfunction
endpackage

// File: rtl/pipeline_perf_cnt.sv
// Stall-cycle and accepted-exception counters for pipeline_ctrl (built only with PERF_CNT_EN).
module pipeline_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_pc,
   input  logic             exc_acc,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   // Both counters wrap naturally at 2^CNT_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_pc) stall_cnt <= stall_cnt + CNT_W'(1);
         if (exc_acc)  flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/exception controller: per-register stall/flush and PC redirect.
// Define PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   if_stallreq,
   input  logic                   id_stallreq,
   input  logic                   ex_stallreq,
   input  logic                   mem_stallreq,
   input  logic                   exc_flag,
   input  logic [31:0]            exc_target,
   output logic [`PIPE_REG_W-1:0] stall,
   output logic [`PIPE_REG_W-1:0] flush,
   output logic                   redir_en,
   output logic [31:0]            redir_pc,
   output logic [CNT_W-1:0]       stall_cnt,
   output logic [CNT_W-1:0]       flush_cnt
);
   logic [0:0]       state_q, state_d;
   logic [31:0]      tgt_q, tgt_d;
   logic [STG_MEM:0] req;
   logic [2:0]       kidx;

   assign req = {mem_stallreq, ex_stallreq, id_stallreq, if_stallreq};

   always_comb begin
      kidx = 3'd0;
      for (int i = STG_IF; i <= STG_MEM; i++)
         if (req[i]) kidx = 3'(i);
   end

   always_comb begin
      stall    = '0;
      flush    = '0;
      redir_en = 1'b0;
      redir_pc = '0;
      state_d  = state_q;
      tgt_d    = tgt_q;
      if (rst) begin
         stall = RST_STALL;
         flush = EXC_FLUSH;
      end else if (state_q == ST_REDIR_WAIT) begin
         // New exceptions and hazards are ignored: the captured target wins.
         flush = EXC_FLUSH;
         if (if_stallreq) begin
            stall[STG_IF] = 1'b1;
         end else begin
            redir_en = 1'b1;
            redir_pc = tgt_q;
            state_d  = ST_RUN;
         end
      end else if (exc_flag) begin
         flush = EXC_FLUSH;
         if (if_stallreq) begin
            // Fetch still in flight: park the target until the I-side bus frees.
            stall[STG_IF] = 1'b1;
            tgt_d         = exc_target;
            state_d       = ST_REDIR_WAIT;
         end else begin
            redir_en = 1'b1;
            redir_pc = exc_target;
         end
      end else if (|req) begin
         stall = hold_mask(kidx);
         flush = bubble_mask(kidx);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

`ifdef PERF_CNT_EN
   logic exc_acc;
   assign exc_acc = ~rst & (state_q == ST_RUN) & exc_flag;

   pipeline_perf_cnt #(.CNT_W(CNT_W)) u_perf (
      .clk       (clk),
      .rst       (rst),
      .stall_pc  (stall[STG_IF]),
      .exc_acc   (exc_acc),
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
   );
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: table-driven steps through a scoreboard queue.
module tb_pipeline_ctrl;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             if_stallreq, id_stallreq, ex_stallreq, mem_stallreq, exc_flag;
   logic [31:0]      exc_target;
   logic [4:0]       stall, flush;
   logic             redir_en;
   logic [31:0]      redir_pc;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int errors = 0;
   int checks = 0;

   // req = {exc, mem, ex, id, if}
   typedef struct packed {
      logic [4:0]  req;
      logic [31:0] tgt;
      logic [4:0]  stall;
      logic [4:0]  flush;
      logic        en;
      logic [31:0] pc;
   } step_t;

   typedef struct packed {
      logic [4:0]  stall;
      logic [4:0]  flush;
      logic        en;
      logic [31:0] pc;
   } exp_t;

   exp_t sb[$];

   pipeline_ctrl #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .if_stallreq  (if_stallreq),
      .id_stallreq  (id_stallreq),
      .ex_stallreq  (ex_stallreq),
      .mem_stallreq (mem_stallreq),
      .exc_flag     (exc_flag),
      .exc_target   (exc_target),
      .stall        (stall),
      .flush        (flush),
      .redir_en     (redir_en),
      .redir_pc     (redir_pc),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic apply_in(input logic [4:0] r, input logic [31:0] t);
      @(posedge clk); #1;
      {exc_flag, mem_stallreq, ex_stallreq, id_stallreq, if_stallreq} = r;
      exc_target = t;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      {exc_flag, mem_stallreq, ex_stallreq, id_stallreq, if_stallreq} = 5'b01111;
      exc_target = 32'h1234_5678;
      sb.push_back('{5'b11111, 5'b11110, 1'b0, 32'h0});
      #3;
      e = sb.pop_front();
      checks++;
      if ({stall, flush, redir_en, redir_pc} !== e) begin
         errors++;
         $display("FAIL reset: got stall=%b flush=%b en=%b pc=%h want stall=%b flush=%b en=%b pc=%h",
                  stall, flush, redir_en, redir_pc, e.stall, e.flush, e.en, e.pc);
      end
      checks++;
      if (stall_cnt !== '0 || flush_cnt !== '0) begin
         errors++;
         $display("FAIL reset_cnt: got stall_cnt=%0d flush_cnt=%0d want 0 0", stall_cnt, flush_cnt);
      end
      @(posedge clk); #1;
      {exc_flag, mem_stallreq, ex_stallreq, id_stallreq, if_stallreq} = '0;
      rst = 1'b0;
   endtask

   task automatic test_stall_prio();
      step_t s[8];
      exp_t  e;
      s = '{
         '{5'b00000, 32'h0, 5'b00000, 5'b00000, 1'b0, 32'h0},
         '{5'b00001, 32'h0, 5'b00001, 5'b00010, 1'b0, 32'h0},
         '{5'b00010, 32'h0, 5'b00011, 5'b00100, 1'b0, 32'h0},
         '{5'b00100, 32'h0, 5'b00111, 5'b01000, 1'b0, 32'h0},
         '{5'b01000, 32'h0, 5'b01111, 5'b10000, 1'b0, 32'h0},
         '{5'b01010, 32'h0, 5'b01111, 5'b10000, 1'b0, 32'h0},
         '{5'b01111, 32'h0, 5'b01111, 5'b10000, 1'b0, 32'h0},
         '{5'b00101, 32'h0, 5'b00111, 5'b01000, 1'b0, 32'h0}
      };
      foreach (s[i]) begin
         apply_in(s[i].req, s[i].tgt);
         sb.push_back('{s[i].stall, s[i].flush, s[i].en, s[i].pc});
         #3;
         e = sb.pop_front();
         checks++;
         if ({stall, flush, redir_en, redir_pc} !== e) begin
            errors++;
            $display("FAIL stall_prio[%0d]: got stall=%b flush=%b en=%b pc=%h want stall=%b flush=%b en=%b pc=%h",
                     i, stall, flush, redir_en, redir_pc, e.stall, e.flush, e.en, e.pc);
         end
      end
   endtask

   task automatic test_exc_now();
      step_t s[2];
      exp_t  e;
      s = '{
         '{5'b11000, 32'hBFC00380, 5'b00000, 5'b11110, 1'b1, 32'hBFC00380},
         '{5'b00000, 32'hBFC00380, 5'b00000, 5'b00000, 1'b0, 32'h0}
      };
      foreach (s[i]) begin
         apply_in(s[i].req, s[i].tgt);
         sb.push_back('{s[i].stall, s[i].flush, s[i].en, s[i].pc});
         #3;
         e = sb.pop_front();
         checks++;
         if ({stall, flush, redir_en, redir_pc} !== e) begin
            errors++;
            $display("FAIL exc_now[%0d]: got stall=%b flush=%b en=%b pc=%h want stall=%b flush=%b en=%b pc=%h",
                     i, stall, flush, redir_en, redir_pc, e.stall, e.flush, e.en, e.pc);
         end
      end
   endtask

   task automatic test_exc_wait();
      step_t s[6];
      exp_t  e;
      // Step 1 tries a second exception and an EX hazard; both must be ignored.
      s = '{
         '{5'b10001, 32'h80000180, 5'b00001, 5'b11110, 1'b0, 32'h0},
         '{5'b10101, 32'hDEADBEEF, 5'b00001, 5'b11110, 1'b0, 32'h0},
         '{5'b00001, 32'h0,        5'b00001, 5'b11110, 1'b0, 32'h0},
         '{5'b00001, 32'h0,        5'b00001, 5'b11110, 1'b0, 32'h0},
         '{5'b01000, 32'h0,        5'b00000, 5'b11110, 1'b1, 32'h80000180},
         '{5'b00000, 32'h0,        5'b00000, 5'b00000, 1'b0, 32'h0}
      };
      foreach (s[i]) begin
         apply_in(s[i].req, s[i].tgt);
         sb.push_back('{s[i].stall, s[i].flush, s[i].en, s[i].pc});
         #3;
         e = sb.pop_front();
         checks++;
         if ({stall, flush, redir_en, redir_pc} !== e) begin
            errors++;
            $display("FAIL exc_wait[%0d]: got stall=%b flush=%b en=%b pc=%h want stall=%b flush=%b en=%b pc=%h",
                     i, stall, flush, redir_en, redir_pc, e.stall, e.flush, e.en, e.pc);
         end
      end
   endtask

   task automatic test_back_to_back();
      step_t s[5];
      exp_t  e;
      s = '{
         '{5'b10000, 32'h0000_1000, 5'b00000, 5'b11110, 1'b1, 32'h0000_1000},
         '{5'b10000, 32'h0000_2000, 5'b00000, 5'b11110, 1'b1, 32'h0000_2000},
         '{5'b10001, 32'h0000_3000, 5'b00001, 5'b11110, 1'b0, 32'h0},
         '{5'b10010, 32'h0000_4000, 5'b00000, 5'b11110, 1'b1, 32'h0000_3000},
         '{5'b00100, 32'h0,         5'b00111, 5'b01000, 1'b0, 32'h0}
      };
      foreach (s[i]) begin
         apply_in(s[i].req, s[i].tgt);
         sb.push_back('{s[i].stall, s[i].flush, s[i].en, s[i].pc});
         #3;
         e = sb.pop_front();
         checks++;
         if ({stall, flush, redir_en, redir_pc} !== e) begin
            errors++;
            $display("FAIL back_to_back[%0d]: got stall=%b flush=%b en=%b pc=%h want stall=%b flush=%b en=%b pc=%h",
                     i, stall, flush, redir_en, redir_pc, e.stall, e.flush, e.en, e.pc);
         end
      end
   endtask

   task automatic test_reset_in_wait();
      exp_t e;
      apply_in(5'b10001, 32'h80000180);   // enter REDIR_WAIT
      apply_in(5'b00001, 32'h0);          // 1st wait cycle
      apply_in(5'b00001, 32'h0);          // 2nd wait cycle
      #1 rst = 1'b1;
      sb.push_back('{5'b11111, 5'b11110, 1'b0, 32'h0});
      #2;
      e = sb.pop_front();
      checks++;
      if ({stall, flush, redir_en, redir_pc} !== e) begin
         errors++;
         $display("FAIL rst_in_wait: got stall=%b flush=%b en=%b pc=%h want stall=%b flush=%b en=%b pc=%h",
                  stall, flush, redir_en, redir_pc, e.stall, e.flush, e.en, e.pc);
      end
      // Release with the I-side free: a surviving REDIR_WAIT would pulse redir_en here.
      for (int i = 0; i < 2; i++) begin
         apply_in(5'b00000, 32'h0);
         if (i == 0) rst = 1'b0;
         sb.push_back('{5'b00000, 5'b00000, 1'b0, 32'h0});
         #3;
         e = sb.pop_front();
         checks++;
         if ({stall, flush, redir_en, redir_pc} !== e) begin
            errors++;
            $display("FAIL rst_release[%0d]: got stall=%b flush=%b en=%b pc=%h want stall=%b flush=%b en=%b pc=%h",
                     i, stall, flush, redir_en, redir_pc, e.stall, e.flush, e.en, e.pc);
         end
      end
      // Back in RUN, a hazard must again produce the normal pattern.
      apply_in(5'b00100, 32'h0);
      sb.push_back('{5'b00111, 5'b01000, 1'b0, 32'h0});
      #3;
      e = sb.pop_front();
      checks++;
      if ({stall, flush, redir_en, redir_pc} !== e) begin
         errors++;
         $display("FAIL rst_run: got stall=%b flush=%b en=%b pc=%h want stall=%b flush=%b en=%b pc=%h",
                  stall, flush, redir_en, redir_pc, e.stall, e.flush, e.en, e.pc);
      end
   endtask

   task automatic test_perf();
      logic [CNT_W-1:0] exp_sc, exp_fc;
      @(posedge clk); #1;
      {exc_flag, mem_stallreq, ex_stallreq, id_stallreq, if_stallreq} = '0;
      rst = 1'b1;
      #2 rst = 1'b0;
`ifdef PERF_CNT_EN
      exp_sc = CNT_W'(17);
      exp_fc = CNT_W'(1);
`else
      exp_sc = '0;
      exp_fc = '0;
`endif
      for (int i = 0; i < 17; i++) apply_in(5'b00001, 32'h0);
      apply_in(5'b10000, 32'h0000_0ABC);  // accepted exception, PC not held
      apply_in(5'b00000, 32'h0);
      #3;
      checks++;
      if (stall_cnt !== exp_sc) begin
         errors++;
         $display("FAIL perf_stall_cnt: got %0d want %0d", stall_cnt, exp_sc);
      end
      checks++;
      if (flush_cnt !== exp_fc) begin
         errors++;
         $display("FAIL perf_flush_cnt: got %0d want %0d", flush_cnt, exp_fc);
      end
   endtask

   initial begin
      test_reset();
      test_stall_prio();
      test_exc_now();
      test_exc_wait();
      test_back_to_back();
      test_reset_in_wait();
      test_perf();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
